// File: rtl/led_breath_pwm.sv
// led_breath_pwm: LED driver fed by the slow divided square wave from the LFOSC
// divider. Brings tick_in into the clk domain as one-cycle tick pulses, and
// drives the LED as off, solid, blink (toggles on ticks) or breathe (a triangular
// duty ramp applied through a PWM generator).
module led_breath_pwm #(
   parameter int unsigned PWM_WIDTH = 6,
   parameter int unsigned DUTY_STEP = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick_in,
   input  logic                 enable,
   input  logic [1:0]           mode,
   output logic                 led,
   output logic [PWM_WIDTH-1:0] duty,
   output logic                 tick_pulse
);

   typedef enum logic [1:0] {
      MODE_OFF     = 2'b00,
      MODE_SOLID   = 2'b01,
      MODE_BLINK   = 2'b10,
      MODE_BREATHE = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RAMP_UP = 3'd1,
      HOLD_HI = 3'd2,
      RAMP_DN = 3'd3,
      HOLD_LO = 3'd4
   } state_e;

   localparam logic [PWM_WIDTH-1:0] DUTY_MAX = '1;
   localparam logic [PWM_WIDTH:0]   MAX_W    = {1'b0, DUTY_MAX};
   localparam logic [PWM_WIDTH:0]   STEP_W   = (PWM_WIDTH + 1)'(DUTY_STEP);

   // Synchroniser chain, edge history and registered tick pulse
   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic hist_q, hist_d;
   logic tick_q, tick_d;

   // PWM datapath
   logic [PWM_WIDTH-1:0] cnt_q, cnt_d;
   logic [PWM_WIDTH-1:0] duty_q, duty_d;
   logic [PWM_WIDTH-1:0] duty_next_q, duty_next_d;
   logic                 cnt_wrap;
   logic                 pwm_raw;

   // Mode tracking, blink state and LED register
   logic [1:0] mode_q, mode_d;
   logic       blink_q, blink_d;
   logic       led_q, led_d;
   mode_e      mode_cur;
   logic       clear;
   logic       advance;

   // Breathe FSM and saturating step arithmetic
   state_e               state_q, state_d;
   logic [PWM_WIDTH:0]   sum_w;
   logic [PWM_WIDTH-1:0] up_sat;
   logic [PWM_WIDTH-1:0] dn_sat;

   // Two-flop synchroniser, history flop, rising-edge detect
   always_comb begin
      sync1_d = tick_in;
      sync2_d = sync1_q;
      hist_d  = sync2_q;
      tick_d  = sync2_q & ~hist_q;
   end

   // Free-running PWM counter, glitch-free duty update at wrap, raw PWM compare
   always_comb begin
      cnt_wrap = (cnt_q == DUTY_MAX);
      cnt_d    = enable ? cnt_q + 1'b1 : '0;
      if (!enable) begin
         duty_d = '0;
      end else if (cnt_wrap) begin
         duty_d = duty_next_q;
      end else begin
         duty_d = duty_q;
      end
      pwm_raw = (cnt_q < duty_q);
   end

   // Mode-change / disable detection; a change discards any coincident tick
   always_comb begin
      mode_cur = mode_e'(mode);
      mode_d   = mode;
      clear    = ~enable | (mode != mode_q);
      advance  = tick_q & ~clear & (mode_cur == MODE_BREATHE);
   end

   // Blink toggle state and LED source select
   always_comb begin
      blink_d = blink_q;
      if (clear) begin
         blink_d = 1'b0;
      end else if (tick_q && mode_cur == MODE_BLINK) begin
         blink_d = ~blink_q;
      end

      led_d = 1'b0;
      if (enable) begin
         case (mode_cur)
            MODE_OFF:     led_d = 1'b0;
            MODE_SOLID:   led_d = 1'b1;
            MODE_BLINK:   led_d = blink_d;
            MODE_BREATHE: led_d = pwm_raw;
            default:      led_d = 1'b0;
         endcase
      end
   end

   // Saturating up/down step of duty_next, computed one bit wider to avoid wrap
   always_comb begin
      sum_w  = {1'b0, duty_next_q} + STEP_W;
      up_sat = (sum_w >= MAX_W) ? DUTY_MAX : sum_w[PWM_WIDTH-1:0];
      dn_sat = ({1'b0, duty_next_q} <= STEP_W) ? '0
                                               : duty_next_q - STEP_W[PWM_WIDTH-1:0];
   end

   // Breathe FSM next-state logic
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = IDLE;
      end else if (advance) begin
         case (state_q)
            IDLE:    state_d = RAMP_UP;
            RAMP_UP: state_d = (up_sat == DUTY_MAX) ? HOLD_HI : RAMP_UP;
            HOLD_HI: state_d = RAMP_DN;
            RAMP_DN: state_d = (dn_sat == '0) ? HOLD_LO : RAMP_DN;
            HOLD_LO: state_d = RAMP_UP;
            default: state_d = IDLE;
         endcase
      end
   end

   // Breathe FSM output: the duty value queued for the next PWM period
   always_comb begin
      duty_next_d = duty_next_q;
      if (clear) begin
         duty_next_d = '0;
      end else if (advance) begin
         case (state_q)
            IDLE, RAMP_UP, HOLD_LO: duty_next_d = up_sat;
            HOLD_HI, RAMP_DN:       duty_next_d = dn_sat;
            default:                duty_next_d = '0;
         endcase
      end
   end

   // State register for every flop in the block
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         hist_q      <= 1'b0;
         tick_q      <= 1'b0;
         cnt_q       <= '0;
         duty_q      <= '0;
         duty_next_q <= '0;
         mode_q      <= '0;
         blink_q     <= 1'b0;
         led_q       <= 1'b0;
         state_q     <= IDLE;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         hist_q      <= hist_d;
         tick_q      <= tick_d;
         cnt_q       <= cnt_d;
         duty_q      <= duty_d;
         duty_next_q <= duty_next_d;
         mode_q      <= mode_d;
         blink_q     <= blink_d;
         led_q       <= led_d;
         state_q     <= state_d;
      end
   end

   assign led        = led_q;
   assign duty       = duty_q;
   assign tick_pulse = tick_q;

endmodule

// File: tb/tb_led_breath_pwm.sv
// Directed bench for led_breath_pwm (PWM_WIDTH=6, DUTY_STEP=8).
module tb_led_breath_pwm;

   logic       clk;
   logic       rst;
   logic       tick_in;
   logic       enable;
   logic [1:0] mode;
   logic       led;
   logic [5:0] duty;
   logic       tick_pulse;

   int n_cmp;
   int n_bad;

   led_breath_pwm #(.PWM_WIDTH(6), .DUTY_STEP(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .tick_in    (tick_in),
      .enable     (enable),
      .mode       (mode),
      .led        (led),
      .duty       (duty),
      .tick_pulse (tick_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // Raise tick_in between edges; returns at the negedge where tick_pulse should be high
   task automatic tick_rise();
      @(negedge clk);
      #2 tick_in = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (tick_pulse !== 1'b1) begin
         n_bad++;
         $display("FAIL tick_pulse_latency: got %b want 1", tick_pulse);
      end
   endtask

   // One breathe tick, then wait for duty to take the new value at a counter wrap
   task automatic breathe_step(input logic [5:0] exp, input int idx);
      logic [5:0] prev;
      logic       changed;
      tick_rise();
      @(negedge clk);
      tick_in = 1'b0;
      prev    = duty;
      changed = 1'b0;
      for (int i = 0; i < 100 && !changed; i++) begin
         @(negedge clk);
         if (duty !== prev) begin
            changed = 1'b1;
            n_cmp++;
            if (dut.cnt_q !== 6'd0) begin
               n_bad++;
               $display("FAIL duty_at_wrap[%0d]: got cnt %0d want 0", idx, dut.cnt_q);
            end
         end
      end
      n_cmp++;
      if (duty !== exp) begin
         n_bad++;
         $display("FAIL breathe_duty[%0d]: got %0d want %0d", idx, duty, exp);
      end
   endtask

   // Align to counter 0 and measure one 64-cycle PWM period on led
   task automatic pwm_measure(input int exp_high);
      logic found;
      logic first;
      logic second;
      int   highs;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (dut.cnt_q == 6'd0) found = 1'b1;
      end
      n_cmp++;
      if (!found) begin
         n_bad++;
         $display("FAIL pwm_align: got no wrap want wrap within 200 cycles");
      end
      first  = led;
      highs  = 0;
      second = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (i > 0) @(negedge clk);
         if (i == 1) second = led;
         if (led === 1'b1) highs++;
      end
      n_cmp++;
      if (highs != exp_high) begin
         n_bad++;
         $display("FAIL pwm_high_count: got %0d want %0d", highs, exp_high);
      end
      n_cmp++;
      if (first !== 1'b0 || second !== (exp_high > 0)) begin
         n_bad++;
         $display("FAIL pwm_rise_phase: got %b%b want 0%b", first, second, exp_high > 0);
      end
   endtask

   task automatic test_reset();
      tick_in = 1'b0;
      enable  = 1'b1;
      mode    = 2'b01;
      rst     = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if (led !== 1'b0 || duty !== 6'd0 || tick_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got led=%b duty=%0d tp=%b want 0 0 0", led, duty, tick_pulse);
         end
      end
      mode = 2'b00;
      rst  = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (led !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_release_led: got %b want 0", led);
      end
   endtask

   task automatic test_sync();
      int extra;
      @(negedge clk);
      #2 tick_in = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (tick_pulse !== 1'b0) begin
         n_bad++;
         $display("FAIL sync_edge1: got %b want 0", tick_pulse);
      end
      @(negedge clk);
      n_cmp++;
      if (tick_pulse !== 1'b0) begin
         n_bad++;
         $display("FAIL sync_edge2: got %b want 0", tick_pulse);
      end
      @(negedge clk);
      n_cmp++;
      if (tick_pulse !== 1'b1) begin
         n_bad++;
         $display("FAIL sync_edge3: got %b want 1", tick_pulse);
      end
      extra = 0;
      repeat (2000) begin
         @(negedge clk);
         if (tick_pulse === 1'b1) extra++;
      end
      n_cmp++;
      if (extra != 0) begin
         n_bad++;
         $display("FAIL sync_single_pulse: got %0d extra want 0", extra);
      end
      #2 tick_in = 1'b0;
      extra = 0;
      repeat (20) begin
         @(negedge clk);
         if (tick_pulse === 1'b1) extra++;
      end
      n_cmp++;
      if (extra != 0) begin
         n_bad++;
         $display("FAIL sync_falling_edge: got %0d pulses want 0", extra);
      end
   endtask

   task automatic test_breathe();
      logic [5:0] exp_tab [18];
      exp_tab = '{6'd8, 6'd16, 6'd24, 6'd32, 6'd40, 6'd48, 6'd56, 6'd63, 6'd55,
                  6'd47, 6'd39, 6'd31, 6'd23, 6'd15, 6'd7, 6'd0, 6'd8, 6'd16};
      do_reset();
      enable = 1'b1;
      mode   = 2'b11;
      repeat (5) @(negedge clk);
      pwm_measure(0);
      for (int i = 0; i < 18; i++) begin
         breathe_step(exp_tab[i], i + 1);
         if (i == 1) pwm_measure(16);
         if (i == 7) pwm_measure(63);
         repeat (400) @(negedge clk);
      end
   endtask

   task automatic test_blink_solid();
      logic [3:0] exp_led;
      logic       prev;
      int         bad;
      exp_led = 4'b0101;
      do_reset();
      enable = 1'b1;
      mode   = 2'b10;
      repeat (5) @(negedge clk);
      n_cmp++;
      if (led !== 1'b0) begin
         n_bad++;
         $display("FAIL blink_entry: got %b want 0", led);
      end
      prev = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick_rise();
         n_cmp++;
         if (led !== prev) begin
            n_bad++;
            $display("FAIL blink_early[%0d]: got %b want %b", i, led, prev);
         end
         @(negedge clk);
         tick_in = 1'b0;
         n_cmp++;
         if (led !== exp_led[i]) begin
            n_bad++;
            $display("FAIL blink_toggle[%0d]: got %b want %b", i, led, exp_led[i]);
         end
         prev = exp_led[i];
         repeat (20) @(negedge clk);
      end
      mode = 2'b01;
      @(negedge clk);
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (led !== 1'b1) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL solid_constant: got %0d low cycles want 0", bad);
      end
      mode = 2'b00;
      @(negedge clk);
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (led !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL off_mode: got %0d high cycles want 0", bad);
      end
   endtask

   task automatic test_collision();
      logic changed;
      do_reset();
      enable = 1'b1;
      mode   = 2'b11;
      repeat (5) @(negedge clk);
      for (int i = 0; i < 5; i++) breathe_step(6'(8 * (i + 1)), 100 + i);
      tick_rise();
      mode = 2'b10;
      @(negedge clk);
      tick_in = 1'b0;
      n_cmp++;
      if (led !== 1'b0) begin
         n_bad++;
         $display("FAIL collision_no_toggle: got %b want 0", led);
      end
      changed = 1'b0;
      for (int i = 0; i < 100 && !changed; i++) begin
         @(negedge clk);
         if (duty !== 6'd40) changed = 1'b1;
      end
      n_cmp++;
      if (duty !== 6'd0 || dut.cnt_q !== 6'd0) begin
         n_bad++;
         $display("FAIL collision_duty_wrap: got duty=%0d cnt=%0d want 0 0", duty, dut.cnt_q);
      end
      repeat (10) @(negedge clk);
      tick_rise();
      @(negedge clk);
      tick_in = 1'b0;
      n_cmp++;
      if (led !== 1'b1) begin
         n_bad++;
         $display("FAIL collision_blink_next: got %b want 1", led);
      end
      mode = 2'b11;
      repeat (5) @(negedge clk);
      breathe_step(6'd8, 200);
   endtask

   task automatic test_enable_reset();
      logic hit;
      int   nz;
      do_reset();
      enable = 1'b1;
      mode   = 2'b11;
      repeat (5) @(negedge clk);
      for (int i = 0; i < 8; i++) breathe_step((i == 7) ? 6'd63 : 6'(8 * (i + 1)), 300 + i);
      breathe_step(6'd55, 308);
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk);
         if (led === 1'b1) hit = 1'b1;
      end
      enable = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (!hit || led !== 1'b0 || duty !== 6'd0 || dut.cnt_q !== 6'd0) begin
         n_bad++;
         $display("FAIL disable_mid_ramp: got hit=%b led=%b duty=%0d cnt=%0d want 1 0 0 0",
                  hit, led, duty, dut.cnt_q);
      end
      nz = 0;
      repeat (20) begin
         @(negedge clk);
         if (dut.cnt_q !== 6'd0 || led !== 1'b0) nz++;
      end
      n_cmp++;
      if (nz != 0) begin
         n_bad++;
         $display("FAIL disable_hold: got %0d active cycles want 0", nz);
      end
      enable = 1'b1;
      repeat (5) @(negedge clk);
      breathe_step(6'd8, 400);
      breathe_step(6'd16, 401);
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk);
         if (led === 1'b1) hit = 1'b1;
      end
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if (!hit || led !== 1'b0 || duty !== 6'd0 || tick_pulse !== 1'b0) begin
         n_bad++;
         $display("FAIL async_reset: got hit=%b led=%b duty=%0d tp=%b want 1 0 0 0",
                  hit, led, duty, tick_pulse);
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_sync();
      test_breathe();
      test_blink_solid();
      test_collision();
      test_enable_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/led_breath_pwm.md
Name: led_breath_pwm

Overview:
- Downstream consumer of the slow divided square wave from the LFOSC ripple divider.
- Synchronises that signal into the oscillator clock domain and extracts one-cycle tick pulses.
- Drives the LED through a PWM generator whose duty is stepped by a breathing state machine.
- Modes are off, solid, blink (follows ticks) and breathe (triangular ramp of duty).

Parameters:
- PWM_WIDTH, 6, duty/PWM counter width; PWM period = 2^PWM_WIDTH clk cycles (156 Hz at 10 kHz).
- DUTY_STEP, 8, duty increment/decrement per tick in breathe mode; must be 1..2^PWM_WIDTH-1.

Ports:
- clk  in  1  LFOSC clock (10 kHz nominal); all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- tick_in  in  1  divided square wave from the divider chain (ripple-clocked, asynchronous to clk).
- enable  in  1  block enable; low forces the LED off.
- mode  in  2  00 off, 01 solid, 10 blink, 11 breathe.
- led  out  1  PWM/level LED drive, registered.
- duty  out  PWM_WIDTH  currently applied duty value.
- tick_pulse  out  1  one-clk pulse per rising edge of tick_in.

Behaviour:
- Reset (rst=0, asynchronous): led=0, duty=0, tick_pulse=0, synchroniser flops=0, PWM counter=0, duty_next=0, FSM=IDLE.
- Synchroniser: two flops on tick_in, then a third flop for edge history.
  - tick_pulse=1 for exactly one cycle when sync=1 and history=0.
  - Latency is 3 clk edges from the first edge sampling tick_in high.
  - No pulse on falling edges. A tick_in high for less than one clk period may be missed; this is acceptable.
- PWM counter: free-running 0..2^PWM_WIDTH-1, wraps to 0. It is held at 0 while enable=0.
- Duty register:
  - duty loads from duty_next only on the cycle the counter wraps (counter==max), so the new duty applies from count 0. This prevents glitches.
  - A raw PWM value is 1 when counter < duty. duty=0 gives constant 0; duty=max gives high for max of 2^W cycles.
- led register source (1 cycle latency):
  - enable=0 or mode=00: led=0.
  - mode=01: led=1 constant, with no PWM gap.
  - mode=10: led toggles on each tick_pulse. It starts at 0 on entry to the mode.
  - mode=11: led = PWM raw value.
- Breathe FSM (advances only on tick_pulse while enable=1 and mode=11):
  - IDLE: next tick -> RAMP_UP with duty_next=DUTY_STEP.
  - RAMP_UP: duty_next += DUTY_STEP, saturating at 2^W-1. Reaching max -> HOLD_HI.
  - HOLD_HI: next tick -> RAMP_DN, duty_next -= DUTY_STEP.
  - RAMP_DN: duty_next -= DUTY_STEP, saturating at 0. Reaching 0 -> HOLD_LO.
  - HOLD_LO: next tick -> RAMP_UP, duty_next += DUTY_STEP.
  - Arithmetic is done at PWM_WIDTH+1 bits before clamping; there is no wrap-around.
- Mode change or enable falling:
  - FSM -> IDLE, duty_next=0, blink state=0 on the next clk.
  - duty itself returns to 0 at the next wrap, or immediately if enable=0.
  - tick_pulse continues to be generated regardless of mode/enable.
- Simultaneous mode change and tick_pulse: the mode change wins and the tick is discarded for FSM and blink.
- Reset mid-ramp: everything returns to reset values immediately; no state survives.

Test Plan:
1. Reset and synchroniser:
   - Stimulus: rst low 5 cycles, then release; tick_in 0->1 asynchronously, held high for 2000 clk.
   - Required response: all outputs 0 during reset; exactly one tick_pulse, 3 edges after first high sample; none on the falling edge.
2. Breathe ramp (PWM_WIDTH=6, DUTY_STEP=8, mode=11, enable=1), with ticks spaced 500 clk:
   - Ticks 1..8: duty goes 8, 16, …, 56, then 63 (saturated).
   - Tick 9: HOLD_HI -> RAMP_DN, duty 55.
   - Descends to 0, then HOLD_LO, then ramps up again.
   - duty changes are observed only at counter wrap.
3. PWM shape:
   - Stimulus: duty=16 settled.
   - Required response: led high exactly 16 of every 64 cycles, with its rising edge 1 cycle after counter=0.
   - At duty=0, led is never high; at duty=63, led is low 1 of 64.
4. Blink and solid:
   - mode=10 with 4 ticks: led goes 1, 0, 1, 0, each change 1 cycle after tick_pulse.
   - mode=01: led=1 constant for 1000 cycles.
   - mode=00: led=0.
5. Mode change collision:
   - Stimulus: in breathe with duty=40, switch mode to 10 on the same cycle as tick_pulse.
   - Required response: FSM=IDLE, blink state=0, and no toggle on that tick; duty reaches 0 at the next wrap.
6. Enable/reset mid-operation:
   - enable 1->0 during RAMP_DN: led=0 next cycle, duty=0, counter held at 0.
   - rst asserted mid-PWM-high: led=0 asynchronously, before the next clk edge.
